seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. Generalises the 4-bit ripple-carry adder/subtractor to WIDTH bits.
- Processes CHUNK bits per clock through a registered carry chain, with a start/busy/done handshake.
- Serves as the shared arithmetic unit for datapaths where a full-width single-cycle ripple chain would break timing.
- Produces the sum/difference plus carry/borrow (C), overflow (V) and zero (Z) status.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be at least 2.
- CHUNK, 4: bits processed per RUN cycle. Must be at least 1 and divide WIDTH exactly. N = WIDTH/CHUNK.

Ports:
- clk  input  1  sole clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- A  input  WIDTH  augend/minuend; captured when start is accepted.
- B  input  WIDTH  addend/subtrahend; captured when start is accepted.
- Op  input  1  operation select: 0 = add, 1 = subtract (A - B). Captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking a valid result.
- S  output  WIDTH  sum/difference.
- C  output  1  add: carry out. Subtract: borrow, i.e. NOT carry out.
- V  output  1  signed overflow.
- Z  output  1  high when S == 0.

Behaviour:
- Reset: rst high at an edge forces state IDLE and clears busy, done, S, C, V, Z and all internal registers to 0. rst has priority over everything else, including mid-RUN; the operation in flight is abandoned and done is never issued for it.
- States:
  - IDLE: busy=0, done=0. start=1 captures A, B, Op; loads carry register = Op and chunk index = 0; goes to RUN.
  - RUN: busy=1.
    - Each edge adds chunk i of A to chunk i of (B XOR {WIDTH{Op}}) plus the carry register.
    - Writes result chunk i into S, updates the carry register, and increments i.
    - On the edge that processes chunk N-1, goes to DONE.
  - DONE: done=1, busy=0, for exactly one cycle. start=1 is accepted exactly as in IDLE and goes to RUN; otherwise goes to IDLE.
- start is ignored in RUN: no capture, no effect on the operation in progress.
- Latency: start sampled at edge k gives done high in the cycle following edge k+N. Back-to-back operations therefore issue one every N+1 cycles.
- Input stability: A, B and Op may change freely after the capture edge; only captured copies are used.
- S visibility: S updates chunk by chunk during RUN and is valid only when done=1.
- Status flags (written on the final RUN edge):
  - C = cout XOR Op_captured.
  - V = carry into bit WIDTH-1 XOR cout. This requires tracking the internal carry into the MSB within the last chunk.
  - Z = (final S == 0).
- Hold: S, C, V and Z hold their values through DONE and IDLE until the next accepted start. On that start they are not cleared; they are overwritten during RUN.
- Arithmetic: modulo 2^WIDTH. No exceptions are raised on overflow.
- CHUNK == WIDTH: N = 1, a single RUN cycle.

Optional Feature:
- Macro SEQ_ADDSUB_SATURATE_EN.
- Defined: when V=1 on the final RUN edge, S is replaced by the signed saturation value.
  - 0 in the MSB with 1s below (most positive) if cout_raw=0, i.e. positive overflow.
  - 1 in the MSB with 0s below (most negative) otherwise.
  - V and C still report the raw condition; Z reflects the saturated S.
  - The substitution happens on the same edge, so latency is unchanged.
- Undefined: S is the wrapped modulo result. No saturation logic is synthesised.

Test Plan (WIDTH=16, CHUNK=4, N=4 unless stated):
- Add: A=0x1234, B=0x0FFF, Op=0, start pulse -> done exactly 4 cycles after the start edge; S=0x2233, C=0, V=0, Z=0. busy high for 4 cycles; done high for exactly 1 cycle.
- Signed overflow on add: A=0x7FFF, B=0x0001, Op=0 -> S=0x8000, C=0, V=1. With SEQ_ADDSUB_SATURATE_EN: S=0x7FFF, V=1.
- Subtract with borrow and negative overflow:
  - A=0x0005, B=0x0007, Op=1 -> S=0xFFFE, C=1, V=0, Z=0.
  - Then A=0x8000, B=0x0001, Op=1 -> S=0x7FFF, C=0, V=1. With saturation: S=0x8000.
- Zero and back-to-back: A=B=0x1234, Op=1 -> S=0x0000, Z=1, C=0. start held high through DONE -> second operation accepted in the DONE cycle, next done 5 cycles after the first done.
- Robustness:
  - start pulsed mid-RUN with different A/B -> ignored; the result matches the first operands.
  - rst asserted in the 2nd RUN cycle -> the next cycle shows busy=0, done=0, S=0, C=V=Z=0, and no done pulse follows.
- Parameter sweep: CHUNK=16 (N=1) and CHUNK=1 (N=16) with random A/B/Op (at least 1000 each) -> S, C, V and Z match the reference model, and done latency equals N.

Source files
------------

// File: rtl/seq_addsub_if.sv
// seq_addsub_if
//   Handshake and data bundle for the sequential adder/subtractor.
//   master : requester side, drives start/A/B/Op, observes busy/done/results
//   slave  : arithmetic unit side, observes the request, drives the results
// Signals:
//   start  request a new operation (sampled on the rising clock edge)
//   A, B   operands (WIDTH bits), Op 0 = add, 1 = subtract (A - B)
//   busy   operation in progress, done one-cycle result-valid pulse
//   S      sum/difference, C carry (add) / borrow (subtract),
//   V      signed overflow, Z result is zero
interface seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;
  logic             Z;

  modport master (
    output start, A, B, Op,
    input  busy, done, S, C, V, Z
  );

  modport slave (
    input  start, A, B, Op,
    output busy, done, S, C, V, Z
  );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub
//   Multi-cycle two's-complement adder/subtractor. Each RUN cycle adds one
//   CHUNK-bit slice of the operands through a registered carry, so the
//   combinational carry chain is only CHUNK bits long. A result is presented
//   with a one-cycle done pulse N = WIDTH/CHUNK cycles after start is accepted.
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits per RUN cycle (>= 1, must divide WIDTH)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   bus    seq_addsub_if slave: start/A/B/Op in, busy/done/S/C/V/Z out
// Optional build macro:
//   SEQ_ADDSUB_SATURATE_EN  when defined, a signed overflow replaces S with the
//                           signed saturation value (V and C stay raw).
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_addsub_if.slave  bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             load;
  logic             step;
  logic             last;

  // Operand copies are shift registers: the active chunk is always the low
  // CHUNK bits, so no wide read mux is needed. b_q already holds B ^ {Op}.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             v_q;
  logic             z_q;

  logic [31:0]      sh;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] sum_ch;
  logic             cout;
  logic             cmsb;
  logic             v_raw;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] s_merge;
  logic [WIDTH-1:0] s_final;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DONE accepts a new start just like IDLE so that
  // back-to-back operations cost N+1 cycles each.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last = (idx_q == IW'(N - 1));

  // One chunk of the ripple add, plus the merge of its result into S.
  // The carry into the MSB is recovered from the MSB sum bit itself
  // (s = a ^ b ^ cin), which is only meaningful on the last chunk.
  always_comb begin
    sh         = 32'(idx_q) * 32'(CHUNK);
    a_ch       = a_q[CHUNK-1:0];
    b_ch       = b_q[CHUNK-1:0];
    sum        = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    sum_ch     = sum[CHUNK-1:0];
    cout       = sum[CHUNK];
    cmsb       = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum_ch[CHUNK-1];
    v_raw      = cmsb ^ cout;
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << sh;
    s_merge    = (s_q & ~chunk_mask) | (WIDTH'(sum_ch) << sh);
    s_final    = s_merge;
`ifdef SEQ_ADDSUB_SATURATE_EN
    // No carry out on overflow means two positives overflowed upward.
    if (v_raw) begin
      s_final = cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Datapath registers. Results are not cleared on a new start; they are
  // overwritten chunk by chunk and the flags only on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else if (load) begin
      a_q     <= bus.A;
      b_q     <= bus.B ^ {WIDTH{bus.Op}};
      op_q    <= bus.Op;
      carry_q <= bus.Op;
      idx_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      carry_q <= cout;
      idx_q   <= idx_q + IW'(1);
      if (last) begin
        s_q <= s_final;
        c_q <= cout ^ op_q;
        v_q <= v_raw;
        z_q <= (s_final == '0);
      end else begin
        s_q <= s_merge;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.S    = s_q;
  assign bus.C    = c_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub
//   Scoreboard bench for seq_addsub. Drivers push the expected result (with
//   the cycle its done pulse must appear) into a per-instance queue; monitors
//   pop and compare on every done. Three instances: CHUNK=4 (directed
//   vectors), CHUNK=16 and CHUNK=1 (corner plus random operand sweeps).
module tb_seq_addsub;
  localparam int W = 16;

`ifdef SEQ_ADDSUB_SATURATE_EN
  localparam logic [W-1:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [W-1:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [W-1:0] EXP_POS_OVF = 16'h8000;
  localparam logic [W-1:0] EXP_NEG_OVF = 16'h7FFF;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t qm[$];
  exp_t q16[$];
  exp_t q1[$];

  seq_addsub_if #(.WIDTH(W)) busm ();
  seq_addsub_if #(.WIDTH(W)) bus16 ();
  seq_addsub_if #(.WIDTH(W)) bus1 ();

  seq_addsub #(.WIDTH(W), .CHUNK(4))  dut_m  (.clk(clk), .rst(rst), .bus(busm));
  seq_addsub #(.WIDTH(W), .CHUNK(16)) dut_16 (.clk(clk), .rst(rst), .bus(bus16));
  seq_addsub #(.WIDTH(W), .CHUNK(1))  dut_1  (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic reportFail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic compareResult(input string tag, input exp_t e, input logic [W-1:0] s,
                               input logic c, input logic v, input logic z);
    checkOutput({tag, " S"}, 32'(s), 32'(e.s));
    checkOutput({tag, " C"}, 32'(c), 32'(e.c));
    checkOutput({tag, " V"}, 32'(v), 32'(e.v));
    checkOutput({tag, " Z"}, 32'(z), 32'(e.z));
    checkOutput({tag, " done cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Independent reference: full-width add, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    logic [W:0] full;
    exp_t       r;
    full = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r.s  = full[W-1:0];
    r.c  = full[W];
    if (op == 1'b0) r.v = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    else            r.v = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
`ifdef SEQ_ADDSUB_SATURATE_EN
    if (r.v) r.s = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    r.z   = (r.s == '0);
    r.cyc = 0;
    return r;
  endfunction

  // Monitors: every done pulse must match the head of its queue.
  always @(negedge clk) begin : mon_m
    exp_t e;
    if (busm.done) begin
      if (qm.size() == 0) reportFail("main done with nothing expected");
      else begin
        e = qm.pop_front();
        compareResult("main", e, busm.S, busm.C, busm.V, busm.Z);
      end
    end
  end

  always @(negedge clk) begin : mon_16
    exp_t e;
    if (bus16.done) begin
      if (q16.size() == 0) reportFail("chunk16 done with nothing expected");
      else begin
        e = q16.pop_front();
        compareResult("chunk16", e, bus16.S, bus16.C, bus16.V, bus16.Z);
      end
    end
  end

  always @(negedge clk) begin : mon_1
    exp_t e;
    if (bus1.done) begin
      if (q1.size() == 0) reportFail("chunk1 done with nothing expected");
      else begin
        e = q1.pop_front();
        compareResult("chunk1", e, bus1.S, bus1.C, bus1.V, bus1.Z);
      end
    end
  end

  // Issue one operation on the CHUNK=4 instance, scramble the inputs after
  // capture, and wait (bounded) for done while counting busy cycles.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                               input logic [W-1:0] s, input logic c, input logic v,
                               input logic z, output int nbusy);
    bit seen;
    @(negedge clk);
    busm.start = 1'b1;
    busm.A     = a;
    busm.B     = b;
    busm.Op    = op;
    qm.push_back('{s: s, c: c, v: v, z: z, cyc: cyc + 5});
    @(negedge clk);
    busm.start = 1'b0;
    busm.A     = ~a;
    busm.B     = ~b;
    busm.Op    = ~op;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (busm.done) seen = 1'b1;
      else begin
        if (busm.busy) nbusy++;
        @(negedge clk);
      end
    end
    if (!seen) reportFail("main done timeout");
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main_seq
    int nb;
    int d1;
    int d2;
    bit seen;
    rst = 1'b1;
    busm.start = 1'b0;  busm.A = '0;  busm.B = '0;  busm.Op = 1'b0;
    bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Op = 1'b0;
    bus1.start = 1'b0;  bus1.A = '0;  bus1.B = '0;  bus1.Op = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busm.busy), 0);
    checkOutput("reset done", 32'(busm.done), 0);
    checkOutput("reset S", 32'(busm.S), 0);
    checkOutput("reset CVZ", 32'({busm.C, busm.V, busm.Z}), 0);
    checkOutput("reset busy chunk16", 32'(bus16.busy), 0);
    checkOutput("reset busy chunk1", 32'(bus1.busy), 0);
    rst = 1'b0;

    fork
      begin : directed
        applyStimulus(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, nb);
        checkOutput("add busy cycles", 32'(nb), 4);
        @(negedge clk);
        checkOutput("done pulse width", 32'(busm.done), 0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, EXP_POS_OVF, 1'b0, 1'b1, 1'b0, nb);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, nb);
        applyStimulus(16'h8000, 16'h0001, 1'b1, EXP_NEG_OVF, 1'b0, 1'b1, 1'b0, nb);

        // Back-to-back: start held high through RUN and DONE.
        @(negedge clk);
        busm.start = 1'b1; busm.A = 16'h1234; busm.B = 16'h1234; busm.Op = 1'b1;
        qm.push_back('{s: 16'h0000, c: 1'b0, v: 1'b0, z: 1'b1, cyc: cyc + 5});
        @(negedge clk);
        busm.A = 16'h0001; busm.B = 16'h0001; busm.Op = 1'b0;
        seen = 1'b0;
        d1 = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
          if (busm.done) begin seen = 1'b1; d1 = cyc; end
          else @(negedge clk);
        end
        if (!seen) reportFail("b2b first done timeout");
        qm.push_back('{s: 16'h0002, c: 1'b0, v: 1'b0, z: 1'b0, cyc: cyc + 5});
        @(negedge clk);
        busm.start = 1'b0;
        seen = 1'b0;
        d2 = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
          if (busm.done) begin seen = 1'b1; d2 = cyc; end
          else @(negedge clk);
        end
        if (!seen) reportFail("b2b second done timeout");
        checkOutput("b2b done spacing", 32'(d2 - d1), 5);

        // start pulsed during RUN with other operands must be ignored.
        @(negedge clk);
        busm.start = 1'b1; busm.A = 16'h1111; busm.B = 16'h2222; busm.Op = 1'b0;
        qm.push_back('{s: 16'h3333, c: 1'b0, v: 1'b0, z: 1'b0, cyc: cyc + 5});
        @(negedge clk);
        busm.start = 1'b0;
        @(negedge clk);
        busm.start = 1'b1; busm.A = 16'hFFFF; busm.B = 16'h7FFF; busm.Op = 1'b1;
        @(negedge clk);
        busm.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
          if (busm.done) seen = 1'b1;
          else @(negedge clk);
        end
        if (!seen) reportFail("mid-run start done timeout");
      end

      begin : sweep16
        logic [W-1:0] corners [4];
        logic [W-1:0] a, b;
        logic         op;
        exp_t         e;
        bit           got;
        corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        for (int i = 0; i < 1032; i++) begin
          @(negedge clk);
          if (i < 32) begin
            a = corners[i % 4]; b = corners[(i / 4) % 4]; op = 1'(i / 16);
          end else begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom_range(0, 1));
          end
          e = model(a, b, op);
          e.cyc = cyc + 2;
          bus16.start = 1'b1; bus16.A = a; bus16.B = b; bus16.Op = op;
          q16.push_back(e);
          @(negedge clk);
          bus16.start = 1'b0;
          got = 1'b0;
          for (int k = 0; k < 5 && !got; k++) begin
            if (bus16.done) got = 1'b1;
            else @(negedge clk);
          end
          if (!got) reportFail("chunk16 done timeout");
        end
      end

      begin : sweep1
        logic [W-1:0] corners [4];
        logic [W-1:0] a, b;
        logic         op;
        exp_t         e;
        bit           got;
        corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        for (int i = 0; i < 1032; i++) begin
          @(negedge clk);
          if (i < 32) begin
            a = corners[(i / 4) % 4]; b = corners[i % 4]; op = 1'(i / 16);
          end else begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom_range(0, 1));
          end
          e = model(a, b, op);
          e.cyc = cyc + 17;
          bus1.start = 1'b1; bus1.A = a; bus1.B = b; bus1.Op = op;
          q1.push_back(e);
          @(negedge clk);
          bus1.start = 1'b0;
          got = 1'b0;
          for (int k = 0; k < 20 && !got; k++) begin
            if (bus1.done) got = 1'b1;
            else @(negedge clk);
          end
          if (!got) reportFail("chunk1 done timeout");
        end
      end
    join

    // Reset in the second RUN cycle abandons the operation.
    @(negedge clk);
    busm.start = 1'b1; busm.A = 16'hABCD; busm.B = 16'h1111; busm.Op = 1'b0;
    @(negedge clk);
    busm.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-run reset busy", 32'(busm.busy), 0);
    checkOutput("mid-run reset done", 32'(busm.done), 0);
    checkOutput("mid-run reset S", 32'(busm.S), 0);
    checkOutput("mid-run reset CVZ", 32'({busm.C, busm.V, busm.Z}), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busm.done) seen = 1'b1;
    end
    checkOutput("no done after reset", 32'(seen), 0);

    checkOutput("main queue drained", 32'(qm.size()), 0);
    checkOutput("chunk16 queue drained", 32'(q16.size()), 0);
    checkOutput("chunk1 queue drained", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
